// File: rtl/fpu_mem_scheduler_pkg.sv
// Shared FPU memory-scheduler definitions: FSM states, default line size
// and the write-back line-count helper.
package fpu_mem_scheduler_pkg;

    localparam int DEFAULT_LINE_BYTES = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2,
        NEXT  = 2'd3
    } sched_state_t;

    // Lines needed for a write-back of 'size' bytes once clipped to the buffer;
    // a zero size needs no lines at all.
    function automatic int unsigned write_line_count(
        input logic [16:0] size,
        input int unsigned buf_bytes,
        input int unsigned line_bytes
    );
        int unsigned clipped;
        clipped = (32'(size) > buf_bytes) ? buf_bytes : 32'(size);
        return (clipped + line_bytes - 32'd1) / line_bytes;
    endfunction

endpackage

// File: rtl/fpu_mem_scheduler.sv
// Line-by-line memory scheduler for the FPU buffer: one pending slot per
// request type, round-robin grant, then one memory handshake per line.
module fpu_mem_scheduler
    import fpu_mem_scheduler_pkg::*;
#(
    parameter int MEM_BUFFER_WIDTH = 512,
    parameter int LINE_BYTES       = DEFAULT_LINE_BYTES,
    localparam int NUM_LINES       = MEM_BUFFER_WIDTH / LINE_BYTES,
    localparam int IDX_W           = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             request_read,
    input  logic [31:0]      read_address,
    input  logic             request_write,
    input  logic [31:0]      write_address,
    input  logic [16:0]      write_request_size,
    output logic             making_request,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    input  logic             mem_ack,
    output logic [IDX_W-1:0] line_idx,
    output logic             overrun
);

    // One extra bit so a full buffer's worth of lines is representable.
    localparam int                CNT_W       = IDX_W + 1;
    localparam logic [31:0]       LINE_STRIDE = 32'(LINE_BYTES);
    localparam logic [CNT_W-1:0]  READ_LINES  = CNT_W'(NUM_LINES);

    sched_state_t     state_q, state_d;

    logic             rd_pend_q, rd_pend_d;
    logic [31:0]      rd_addr_q, rd_addr_d;
    logic             wr_pend_q, wr_pend_d;
    logic [31:0]      wr_addr_q, wr_addr_d;
    logic [16:0]      wr_size_q, wr_size_d;

    logic             last_read_q, last_read_d;
    logic [31:0]      act_base_q, act_base_d;
    logic             act_we_q, act_we_d;
    logic [CNT_W-1:0] act_lines_q, act_lines_d;
    logic [IDX_W-1:0] line_idx_q, line_idx_d;

    logic             overrun_q, overrun_d;
    logic             busy_q, busy_d;

    logic             grant_read;
    logic             consume_rd;
    logic             consume_wr;
    logic [CNT_W-1:0] wr_lines;
    logic [CNT_W-1:0] next_idx;

    // Read wins unless a write is also waiting and read was the last type served.
    assign grant_read = rd_pend_q && (!wr_pend_q || !last_read_q);
    assign wr_lines   = CNT_W'(write_line_count(wr_size_q,
                                                $unsigned(MEM_BUFFER_WIDTH),
                                                $unsigned(LINE_BYTES)));
    assign next_idx   = CNT_W'(line_idx_q) + CNT_W'(1);

    // Next-state logic plus slot bookkeeping, arbitration and transfer setup.
    always_comb begin
        state_d     = state_q;
        rd_pend_d   = rd_pend_q;
        rd_addr_d   = rd_addr_q;
        wr_pend_d   = wr_pend_q;
        wr_addr_d   = wr_addr_q;
        wr_size_d   = wr_size_q;
        last_read_d = last_read_q;
        act_base_d  = act_base_q;
        act_we_d    = act_we_q;
        act_lines_d = act_lines_q;
        line_idx_d  = line_idx_q;
        overrun_d   = overrun_q;
        consume_rd  = 1'b0;
        consume_wr  = 1'b0;

        case (state_q)
            IDLE: begin
                if (rd_pend_q || wr_pend_q) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                line_idx_d = '0;
                if (grant_read) begin
                    consume_rd  = 1'b1;
                    act_base_d  = rd_addr_q;
                    act_we_d    = 1'b0;
                    act_lines_d = READ_LINES;
                    last_read_d = 1'b1;
                    state_d     = XFER;
                end else if (wr_pend_q) begin
                    // A zero-byte write-back is retired here without touching memory.
                    consume_wr  = 1'b1;
                    act_base_d  = wr_addr_q;
                    act_we_d    = 1'b1;
                    act_lines_d = wr_lines;
                    last_read_d = 1'b0;
                    state_d     = (wr_lines == '0) ? IDLE : XFER;
                end else begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                if (mem_ack) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (next_idx < act_lines_q) begin
                    line_idx_d = line_idx_q + IDX_W'(1);
                    state_d    = XFER;
                end else begin
                    line_idx_d = '0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A fresh pulse beats a same-edge grant, so the newer request is kept.
        if (consume_rd) begin
            rd_pend_d = 1'b0;
        end
        if (request_read) begin
            rd_pend_d = 1'b1;
            rd_addr_d = read_address;
            if (rd_pend_q && !consume_rd) begin
                overrun_d = 1'b1;
            end
        end

        if (consume_wr) begin
            wr_pend_d = 1'b0;
        end
        if (request_write) begin
            wr_pend_d = 1'b1;
            wr_addr_d = write_address;
            wr_size_d = write_request_size;
            if (wr_pend_q && !consume_wr) begin
                overrun_d = 1'b1;
            end
        end

        busy_d = rd_pend_d || wr_pend_d || (state_d != IDLE);
    end

    // State and datapath registers; reset also restores read priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
            wr_pend_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_size_q   <= '0;
            last_read_q <= 1'b0;
            act_base_q  <= '0;
            act_we_q    <= 1'b0;
            act_lines_q <= '0;
            line_idx_q  <= '0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_pend_q   <= rd_pend_d;
            rd_addr_q   <= rd_addr_d;
            wr_pend_q   <= wr_pend_d;
            wr_addr_q   <= wr_addr_d;
            wr_size_q   <= wr_size_d;
            last_read_q <= last_read_d;
            act_base_q  <= act_base_d;
            act_we_q    <= act_we_d;
            act_lines_q <= act_lines_d;
            line_idx_q  <= line_idx_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign making_request = busy_q;
    assign mem_req        = (state_q == XFER);
    assign mem_we         = mem_req && act_we_q;
    assign mem_addr       = act_base_q + 32'(line_idx_q) * LINE_STRIDE;
    assign line_idx       = line_idx_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_fpu_mem_scheduler.sv
// Self-checking bench for fpu_mem_scheduler: directed scenarios followed by
// randomized requests, compared against a line-list reference model.
module tb_fpu_mem_scheduler;

    localparam int MBW    = 512;
    localparam int LB     = 64;
    localparam int NLINES = MBW / LB;
    localparam int IDX_W  = $clog2(NLINES);

    logic             clk;
    logic             rst_n;
    logic             request_read;
    logic [31:0]      read_address;
    logic             request_write;
    logic [31:0]      write_address;
    logic [16:0]      write_request_size;
    logic             making_request;
    logic             mem_req;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic             mem_ack;
    logic [IDX_W-1:0] line_idx;
    logic             overrun;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          hs_count = 0;
    int          ack_max  = 0;
    int          wait_cnt = 0;
    bit          stray_en = 1'b0;
    bit          model_last_read = 1'b0;
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];

    fpu_mem_scheduler #(
        .MEM_BUFFER_WIDTH(MBW),
        .LINE_BYTES      (LB)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .request_read      (request_read),
        .read_address      (read_address),
        .request_write     (request_write),
        .write_address     (write_address),
        .write_request_size(write_request_size),
        .making_request    (making_request),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_ack           (mem_ack),
        .line_idx          (line_idx),
        .overrun           (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached with test still running");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] pack_line(input logic we, input logic [IDX_W-1:0] idx,
                                              input logic [31:0] addr);
        return {28'd0, we, idx, addr};
    endfunction

    // Reference model: every request expands into its list of memory lines.
    function automatic void model_read(input logic [31:0] addr);
        for (int i = 0; i < NLINES; i++)
            exp_q.push_back(pack_line(1'b0, IDX_W'(i), addr + 32'(i * LB)));
        model_last_read = 1'b1;
    endfunction

    function automatic void model_write(input logic [31:0] addr, input int size);
        int clipped;
        int n;
        clipped = (size > MBW) ? MBW : size;
        n = (clipped + LB - 1) / LB;
        for (int i = 0; i < n; i++)
            exp_q.push_back(pack_line(1'b1, IDX_W'(i), addr + 32'(i * LB)));
        model_last_read = 1'b0;
    endfunction

    function automatic void model_both(input logic [31:0] raddr, input logic [31:0] waddr,
                                       input int size);
        if (!model_last_read) begin
            model_read(raddr);
            model_write(waddr, size);
        end else begin
            model_write(waddr, size);
            model_read(raddr);
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Caller sits just after a rising edge; the pulse is sampled on the next one.
    task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] raddr,
                                 input logic [31:0] waddr, input int wsize);
        request_read       = rd;
        request_write      = wr;
        read_address       = raddr;
        write_address      = waddr;
        write_request_size = 17'(wsize);
        @(posedge clk); #1;
        request_read  = 1'b0;
        request_write = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int cyc;
        cyc = 0;
        while (making_request && cyc < 2000) begin
            @(negedge clk); #1;
            cyc++;
        end
        checkOutput({tag, "_idle"}, 64'(making_request), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic waitHandshakes(input int target, input string tag);
        int cyc;
        cyc = 0;
        while (hs_count < target && cyc < 500) begin
            @(negedge clk); #1;
            cyc++;
        end
        checkOutput({tag, "_hs_reached"}, 64'(hs_count >= target), 64'd1);
    endtask

    task automatic compareTraffic(input string tag);
        checkOutput({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            checkOutput($sformatf("%s_line%0d", tag, i), obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    // Memory responder: acks a request after a random delay, optionally pulsing stray acks.
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n || mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req) begin
                if (wait_cnt == 0) begin
                    mem_ack  = 1'b1;
                    wait_cnt = int'($urandom_range(ack_max, 0));
                end else begin
                    wait_cnt--;
                end
            end else if (stray_en && ($urandom_range(3, 0) == 0)) begin
                mem_ack = 1'b1;
            end
        end
    end

    // Monitor: records every completed line handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && mem_req && mem_ack) begin
                obs_q.push_back(pack_line(mem_we, line_idx, mem_addr));
                hs_count++;
            end
        end
    end

    initial begin
        int base;
        int cnt;
        bit gap;

        rst_n = 1'b0;
        request_read = 1'b0;
        request_write = 1'b0;
        read_address = '0;
        write_address = '0;
        write_request_size = '0;
        $display("[TB] fpu_mem_scheduler bench starting");

        #12;
        checkOutput("rst_busy",    64'(making_request), 64'd0);
        checkOutput("rst_mem_req", 64'(mem_req),        64'd0);
        checkOutput("rst_mem_we",  64'(mem_we),         64'd0);
        checkOutput("rst_addr",    64'(mem_addr),       64'd0);
        checkOutput("rst_idx",     64'(line_idx),       64'd0);
        checkOutput("rst_overrun", 64'(overrun),        64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Full read fill, ack one cycle after each request.
        ack_max = 0;
        model_read(32'h1000_0200);
        base = hs_count;
        applyStimulus(1'b1, 1'b0, 32'h1000_0200, 32'h0, 0);
        waitHandshakes(base + NLINES, "read8");
        checkOutput("read8_busy_at_last_ack", 64'(making_request), 64'd1);
        @(negedge clk); #1;
        checkOutput("read8_busy_in_last_next", 64'(making_request), 64'd1);
        @(negedge clk); #1;
        checkOutput("read8_busy_dropped", 64'(making_request), 64'd0);
        compareTraffic("read8");
        @(posedge clk); #1;

        // Partial write-back: 130 bytes needs three lines.
        model_write(32'h2000_0000, 130);
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h2000_0000, 130);
        waitIdle("wr130");
        compareTraffic("wr130");

        // Simultaneous pairs alternate read, write, read, write.
        ack_max = 2;
        model_both(32'h3000_0000, 32'h4000_0000, 200);
        applyStimulus(1'b1, 1'b1, 32'h3000_0000, 32'h4000_0000, 200);
        waitIdle("pair1");
        model_both(32'h3000_1000, 32'h4000_1000, 64);
        applyStimulus(1'b1, 1'b1, 32'h3000_1000, 32'h4000_1000, 64);
        waitIdle("pair2");
        compareTraffic("pairs");

        // Zero-byte write-back: no traffic, short busy window.
        model_write(32'h5000_0000, 0);
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h5000_0000, 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (!making_request) break;
            cnt++;
        end
        checkOutput("zero_busy_window", 64'((cnt >= 2) && (cnt <= 3)), 64'd1);
        compareTraffic("zero");
        @(posedge clk); #1;

        // A new read landing in the final NEXT cycle keeps busy continuously high.
        ack_max = 1;
        model_read(32'h6000_0000);
        model_read(32'h6100_0040);
        base = hs_count;
        applyStimulus(1'b1, 1'b0, 32'h6000_0000, 32'h0, 0);
        waitHandshakes(base + NLINES, "chain_first");
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 32'h6100_0040, 32'h0, 0);
        gap = 1'b0;
        for (int i = 0; i < 200 && hs_count < base + 2 * NLINES; i++) begin
            @(negedge clk); #1;
            if (!making_request) gap = 1'b1;
        end
        checkOutput("chain_no_busy_gap", 64'(gap), 64'd0);
        waitIdle("chain");
        compareTraffic("chain");
        checkOutput("chain_no_overrun", 64'(overrun), 64'd0);

        // Two reads before the first grant: second address wins, overrun sticks.
        ack_max = 2;
        model_read(32'h7000_0000);
        applyStimulus(1'b1, 1'b0, 32'h7700_0000, 32'h0, 0);
        applyStimulus(1'b1, 1'b0, 32'h7000_0000, 32'h0, 0);
        checkOutput("overrun_set", 64'(overrun), 64'd1);
        waitIdle("overrun");
        compareTraffic("overrun");
        checkOutput("overrun_sticky", 64'(overrun), 64'd1);

        // Reset in the middle of line 4 of a read.
        applyStimulus(1'b1, 1'b0, 32'h8000_0000, 32'h0, 0);
        cnt = 0;
        while (!(mem_req && line_idx == IDX_W'(4)) && cnt < 200) begin
            @(negedge clk); #1;
            cnt++;
        end
        checkOutput("midrst_reached_line4", 64'(line_idx), 64'd4);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy",    64'(making_request), 64'd0);
        checkOutput("midrst_mem_req", 64'(mem_req),        64'd0);
        checkOutput("midrst_mem_we",  64'(mem_we),         64'd0);
        checkOutput("midrst_addr",    64'(mem_addr),       64'd0);
        checkOutput("midrst_idx",     64'(line_idx),       64'd0);
        checkOutput("midrst_overrun", 64'(overrun),        64'd0);
        obs_q.delete();
        exp_q.delete();
        model_last_read = 1'b0;
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        model_both(32'h9000_0000, 32'h9100_0000, 100);
        applyStimulus(1'b1, 1'b1, 32'h9000_0000, 32'h9100_0000, 100);
        waitIdle("post_rst");
        compareTraffic("post_rst");

        // Randomized requests with random ack latency and stray acks.
        ack_max  = 3;
        stray_en = 1'b1;
        for (int it = 0; it < 24; it++) begin
            int          kind;
            int          wsize;
            logic [31:0] raddr;
            logic [31:0] waddr;
            kind  = int'($urandom_range(2, 0));
            raddr = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FF00 + ($urandom & 32'hFF)) : $urandom;
            waddr = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FF00 + ($urandom & 32'hFF)) : $urandom;
            case ($urandom_range(4, 0))
                0:       wsize = int'($urandom_range(700, 0));
                1:       wsize = 131071;
                2:       wsize = 0;
                3:       wsize = 512 + int'($urandom_range(1, 0));
                default: wsize = int'($urandom_range(64, 1));
            endcase
            case (kind)
                0: begin
                    model_read(raddr);
                    applyStimulus(1'b1, 1'b0, raddr, waddr, wsize);
                end
                1: begin
                    model_write(waddr, wsize);
                    applyStimulus(1'b0, 1'b1, raddr, waddr, wsize);
                end
                default: begin
                    model_both(raddr, waddr, wsize);
                    applyStimulus(1'b1, 1'b1, raddr, waddr, wsize);
                end
            endcase
            waitIdle($sformatf("rand%0d", it));
            compareTraffic($sformatf("rand%0d", it));
        end
        stray_en = 1'b0;
        checkOutput("final_overrun", 64'(overrun), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
